// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// ovf exists only when CLA_OVF_EN is defined.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    modport master (
`ifdef CLA_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co
    );

    modport slave (
`ifdef CLA_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves STAGE_GROUPS lookahead groups.
// Define CLA_OVF_EN to add a registered two's-complement overflow flag (ovf).
module cla_pipe_adder #(
    parameter int WIDTH        = 16,
    parameter int GROUP        = 4,
    parameter int STAGE_GROUPS = 1
) (
    input logic             clk,
    input logic             rst,
    cla_pipe_adder_if.slave io
);
    localparam int SW     = GROUP * STAGE_GROUPS;
    localparam int NSTAGE = WIDTH / SW;

    // Two-level lookahead: group G/P from bits, group carries from G/P, then bit carries per group.
    function automatic logic [SW:0] cla_carries(input logic [SW-1:0] g, input logic [SW-1:0] p,
                                                input logic c0);
        logic [STAGE_GROUPS-1:0] gg;
        logic [STAGE_GROUPS-1:0] gp;
        logic [STAGE_GROUPS:0]   gc;
        logic [SW:0]             c;
        logic                    acc;
        logic                    pr;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int j = 0; j < STAGE_GROUPS; j++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int i = GROUP - 1; i >= 0; i--) begin
                acc = acc | (g[j*GROUP+i] & pr);
                pr  = pr & p[j*GROUP+i];
            end
            gg[j] = acc;
            gp[j] = pr;
        end
        gc[0] = c0;
        for (int j = 0; j < STAGE_GROUPS; j++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int m = j; m >= 0; m--) begin
                acc = acc | (gg[m] & pr);
                pr  = pr & gp[m];
            end
            gc[j+1] = acc | (pr & c0);
        end
        for (int j = 0; j <= STAGE_GROUPS; j++) c[j*GROUP] = gc[j];
        for (int j = 0; j < STAGE_GROUPS; j++) begin
            for (int i = 1; i < GROUP; i++) begin
                acc = 1'b0;
                pr  = 1'b1;
                for (int m = i - 1; m >= 0; m--) begin
                    acc = acc | (g[j*GROUP+m] & pr);
                    pr  = pr & p[j*GROUP+m];
                end
                c[j*GROUP+i] = acc | (pr & gc[j]);
            end
        end
        return c;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bx;

    assign bx = io.b ^ {WIDTH{io.sub}};

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int RW = WIDTH - k * SW;  // operand bits not yet consumed

        logic [RW-1:0]       ain;
        logic [RW-1:0]       bin;
        logic                cin;
        logic                vin;
        logic [SW:0]         bc;
        logic [SW-1:0]       ssum;
        logic [(k+1)*SW-1:0] sum_d;
        logic [(k+1)*SW-1:0] sum_q;
        logic                vld_q;
        logic                cout_q;

        if (k == 0) begin : g_head
            assign ain   = io.a;
            assign bin   = bx;
            assign cin   = io.ci ^ io.sub;
            assign vin   = io.in_valid;
            assign sum_d = ssum;
        end else begin : g_body
            assign ain   = g_stg[k-1].g_fwd.a_q;
            assign bin   = g_stg[k-1].g_fwd.b_q;
            assign cin   = g_stg[k-1].cout_q;
            assign vin   = g_stg[k-1].vld_q;
            assign sum_d = {ssum, g_stg[k-1].sum_q};
        end

        assign bc   = cla_carries(ain[SW-1:0] & bin[SW-1:0], ain[SW-1:0] ^ bin[SW-1:0], cin);
        assign ssum = ain[SW-1:0] ^ bin[SW-1:0] ^ bc[SW-1:0];

        // Data only loads with a valid beat so s/co hold the last result across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                sum_q  <= '0;
            end else if (adv) begin
                vld_q <= vin;
                if (vin) begin
                    cout_q <= bc[SW];
                    sum_q  <= sum_d;
                end
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && vin) begin
                    a_q <= ain[RW-1:SW];
                    b_q <= bin[RW-1:SW];
                end
            end
        end
    end

    assign adv          = io.out_ready | ~g_stg[NSTAGE-1].vld_q;
    assign io.in_ready  = adv;
    assign io.out_valid = g_stg[NSTAGE-1].vld_q;
    assign io.s         = g_stg[NSTAGE-1].sum_q;
    assign io.co        = g_stg[NSTAGE-1].cout_q;

`ifdef CLA_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv && g_stg[NSTAGE-1].vin) begin
            ovf_q <= g_stg[NSTAGE-1].bc[SW-1] ^ g_stg[NSTAGE-1].bc[SW];
        end
    end

    assign io.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: 16-bit 4-stage instance plus a 4-bit single-stage instance.
module tb_cla_pipe_adder;
    localparam int W   = 16;
    localparam int G   = 4;
    localparam int SG  = 1;
    localparam int NST = W / (G * SG);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();
    cla_pipe_adder_if #(.WIDTH(4)) bus4 ();

    cla_pipe_adder #(.WIDTH(W), .GROUP(G), .STAGE_GROUPS(SG)) dut (
        .clk(clk), .rst(rst), .io(bus.slave)
    );
    cla_pipe_adder #(.WIDTH(4), .GROUP(4), .STAGE_GROUPS(1)) dut4 (
        .clk(clk), .rst(rst), .io(bus4.slave)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks  = 0;
    int   errors  = 0;
    int   run     = 0;
    int   max_run = 0;
    bit   done    = 0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit ci, input bit sub);
        exp_t   e;
        longint m, u, sa, sb, r;
        m     = longint'(1) << w;
        u     = sub ? (a - b - longint'(ci)) : (a + b + longint'(ci));
        e.co  = sub ? (u >= 0) : (u >= m);
        e.s   = W'(((u % m) + m) % m);
        sa    = (a >= m / 2) ? a - m : a;
        sb    = (b >= m / 2) ? b - m : b;
        r     = sub ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
        e.ovf = (r >= m / 2) || (r < -(m / 2));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid dropped.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub, output int waited);
        waited      = 0;
        bus.a       = a;
        bus.b       = b;
        bus.ci      = ci;
        bus.sub     = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            q.push_back(model(W, longint'(a), longint'(b), ci, sub));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_latency(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n), 32'(NST - 1));
    endtask

    // Monitor: pops on each output handshake and compares with the model.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got s=%h co=%b with no beat outstanding", bus.s, bus.co);
            end else begin
                me = q.pop_front();
                if (bus.s !== me.s || bus.co !== me.co
`ifdef CLA_OVF_EN
                    || bus.ovf !== me.ovf
`endif
                ) begin
                    errors++;
                    $display("FAIL result: got s=%h co=%b expected s=%h co=%b ovf=%b",
                             bus.s, bus.co, me.s, me.co, me.ovf);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   wsum;
        exp_t e4;
        logic [W-1:0] ra;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.ci        = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_co", 32'(bus.co), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef CLA_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-stage instance: result one edge after accept.
        bus4.a = 4'b1100; bus4.b = 4'b1100; bus4.ci = 1'b1; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        e4 = model(4, 64'hC, 64'hC, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus4.a = 4'b1100; bus4.b = 4'b0011; bus4.ci = 1'b1;
        chk("w4_valid_a", 32'(bus4.out_valid), 32'd1);
        chk("w4_s_a", 32'(bus4.s), 32'(e4.s[3:0]));
        chk("w4_co_a", 32'(bus4.co), 32'(e4.co));
        e4 = model(4, 64'hC, 64'h3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        chk("w4_s_b", 32'(bus4.s), 32'(e4.s[3:0]));
        chk("w4_co_b", 32'(bus4.co), 32'(e4.co));
        @(posedge clk);
        #1;
        chk("w4_idle", 32'(bus4.out_valid), 32'd0);

        // Carry ripples across every stage boundary.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        wait_latency("latency_wrap");
        drain();

        send(16'h0005, 16'h0007, 1'b0, 1'b1, w);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, w);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, w);
        send(16'h0000, 16'hFFFF, 1'b1, 1'b1, w);
        drain();

        // Back-to-back streaming.
        max_run = 0;
        wsum    = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0, w);
            wsum += w;
        end
        drain();
        chk("stream_in_ready", 32'(wsum), 32'd0);
        chk("stream_run", 32'(max_run), 32'd8);

        // Full pipe stalled for 3 cycles with a beat held at the input.
        for (int i = 0; i < NST; i++) send(16'(16'h1000 + i), 16'h0F0F, 1'(i % 2), 1'(i / 2), w);
        bus.out_ready = 1'b0;
        fork
            send(16'h1234, 16'h4321, 1'b1, 1'b0, w);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("bp_s", 32'(bus.s), 32'(q[0].s));
                    chk("bp_co", 32'(bus.co), 32'(q[0].co));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random operands against random downstream backpressure.
        done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
                    send(ra, 16'($urandom), 1'($urandom % 2), 1'($urandom % 2), w);
                    if ($urandom % 4 == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom % 3) != 0;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(16'(16'h00A0 + i), 16'h0101, 1'b0, 1'b0, w);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_s", 32'(bus.s), 32'd0);
        chk("mid_rst_co", 32'(bus.co), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (NST + 2) @(posedge clk);
        #1;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, w);
        wait_latency("latency_after_rst");
        drain();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
